// File: rtl/isqrt_if.sv
// Start/busy/done handshake bundle for the iterative integer square root.
//   start   : request from the master, sampled by the slave only when idle
//   num     : unsigned operand, captured on the accepting edge
//   busy    : slave is calculating or presenting a result
//   done    : one-cycle pulse, root/rem/perfect valid while high
//   root    : floor(sqrt(num))
//   rem     : num - root*root
//   perfect : rem == 0
interface isqrt_if #(
  parameter int WIDTH = 6
);
  localparam int HALF = WIDTH / 2;

  logic              start;
  logic [WIDTH-1:0]  num;
  logic              busy;
  logic              done;
  logic [HALF-1:0]   root;
  logic [HALF:0]     rem;
  logic              perfect;

  modport master (
    output start, num,
    input  busy, done, root, rem, perfect
  );

  modport slave (
    input  start, num,
    output busy, done, root, rem, perfect
  );
endinterface

// File: rtl/isqrt_seq.sv
// Iterative integer square root, one root bit per clock (radix-4 digit
// recurrence). Operand of WIDTH bits (even, >= 2), root of WIDTH/2 bits.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, priority over everything
//   bus  : isqrt_if slave modport (start/num in; busy/done/root/rem/perfect out)
// Results are registered on the edge that completes the last iteration and
// hold until the next completion; done pulses for the single DONE cycle.
module isqrt_seq #(
  parameter int WIDTH = 6
) (
  input  logic   clk,
  input  logic   rst,
  isqrt_if.slave bus
);
  localparam int HALF = WIDTH / 2;
  // Partial remainder needs two headroom bits for the shifted-in digit pair.
  localparam int RW   = HALF + 2;
  localparam int CW   = $clog2(HALF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [HALF-1:0]   q_q, q_d;
  logic [RW-1:0]     r_q, r_d;
  logic [HALF-1:0]   root_q, root_d;
  logic [HALF:0]     rem_q, rem_d;
  logic              perfect_q, perfect_d;

  // One recurrence step on the current partial state.
  logic [RW-1:0]     r_shift;
  logic [RW-1:0]     trial;
  logic              take;
  logic [RW-1:0]     r_it;
  logic [HALF-1:0]   q_it;

  always_comb begin
    // r < 2^HALF before every step, so the truncating cast drops only zeros.
    r_shift = RW'({r_q, x_q[WIDTH-1 -: 2]});
    trial   = {q_q, 2'b01};
    take    = (r_shift >= trial);
    r_it    = take ? (r_shift - trial) : r_shift;
    q_it    = HALF'({q_q, take});
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    q_d       = q_q;
    r_d       = r_q;
    root_d    = root_q;
    rem_d     = rem_q;
    perfect_d = perfect_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.num;
          q_d     = '0;
          r_d     = '0;
          cnt_d   = CW'(HALF);
          state_d = CALC;
        end
      end
      CALC: begin
        x_d   = x_q << 2;
        q_d   = q_it;
        r_d   = r_it;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // r <= 2*root always fits HALF+1 bits.
          root_d    = q_it;
          rem_d     = (HALF + 1)'(r_it);
          perfect_d = (r_it == '0);
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      x_q       <= '0;
      q_q       <= '0;
      r_q       <= '0;
      root_q    <= '0;
      rem_q     <= '0;
      perfect_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      q_q       <= q_d;
      r_q       <= r_d;
      root_q    <= root_d;
      rem_q     <= rem_d;
      perfect_q <= perfect_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.root    = root_q;
  assign bus.rem     = rem_q;
  assign bus.perfect = perfect_q;
endmodule

// File: tb/tb_isqrt_seq.sv
module tb_isqrt_seq;
  localparam int WIDTH = 6;
  localparam int HALF  = WIDTH / 2;

  logic clk;
  logic rst;

  isqrt_if #(.WIDTH(WIDTH)) bus ();

  isqrt_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_sqrt(input int n);
    int s = 0;
    while ((s + 1) * (s + 1) <= n) s++;
    return s;
  endfunction

  // Transaction-level model: an accepted request occupies HALF+1 busy
  // cycles, the last of which is the done cycle with the new result.
  int m_left    = 0;
  int m_num     = 0;
  int m_root    = 0;
  int m_rem     = 0;
  int m_perfect = 0;
  bit m_valid   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_root = 0; m_rem = 0; m_perfect = 0;
      m_valid = 1'b1;
    end else if (m_left == 0) begin
      if (bus.start) begin
        m_left = HALF + 1;
        m_num  = int'(bus.num);
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_root    = model_sqrt(m_num);
        m_rem     = m_num - m_root * m_root;
        m_perfect = (m_rem == 0) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_busy",    int'(bus.busy),    (m_left != 0) ? 1 : 0);
      check("cyc_done",    int'(bus.done),    (m_left == 1) ? 1 : 0);
      check("cyc_root",    int'(bus.root),    m_root);
      check("cyc_rem",     int'(bus.rem),     m_rem);
      check("cyc_perfect", int'(bus.perfect), m_perfect);
    end
  end

  // Issue one request and wait (bounded) for its done pulse.
  task automatic run_op(input int n, output int r, output int rm, output int pf);
    bit seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num   = WIDTH'(n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.num   = '0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("done_seen", int'(seen), 1);
    r  = int'(bus.root);
    rm = int'(bus.rem);
    pf = int'(bus.perfect);
    $display("op num=%0d root=%0d rem=%0d perfect=%0d", n, r, rm, pf);
  endtask

  int r, rm, pf;
  int dcount, lowcount, last_done, k_done;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_root", int'(bus.root), 0);
    check("rst_rem",  int'(bus.rem),  0);
    check("rst_perf", int'(bus.perfect), 0);
    rst = 1'b0;

    // Latency: done exactly in the 3rd negedge after the accept edge.
    @(negedge clk);
    bus.start = 1'b1; bus.num = 6'd49;
    k_done = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done && k_done < 0) k_done = k;
    end
    check("lat_k", k_done, 3);
    check("lat_root", int'(bus.root), 7);
    check("lat_rem",  int'(bus.rem),  0);
    check("lat_perf", int'(bus.perfect), 1);
    $display("op num=49 done_at=%0d", k_done);

    run_op(63, r, rm, pf);
    check("n63_root", r, 7); check("n63_rem", rm, 14); check("n63_perf", pf, 0);
    run_op(0, r, rm, pf);
    check("n0_root", r, 0); check("n0_rem", rm, 0); check("n0_perf", pf, 1);
    run_op(50, r, rm, pf);
    check("n50_root", r, 7); check("n50_rem", rm, 1); check("n50_perf", pf, 0);

    for (int n = 0; n < 64; n++) begin
      run_op(n, r, rm, pf);
      check("ex_sum", r * r + rm, n);
      check("ex_bound", (rm <= 2 * r) ? 1 : 0, 1);
    end
    for (int s = 0; s < 8; s++) begin
      run_op(s * s, r, rm, pf);
      check("sq_root", r, s);
      check("sq_perf", pf, 1);
    end

    // Second start during CALC must be ignored: one pulse, first result.
    @(negedge clk);
    bus.start = 1'b1; bus.num = 6'd49;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.num = 6'd10;
    @(negedge clk);
    bus.start = 1'b0;
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.done) begin
        dcount++;
        check("ign_root", int'(bus.root), 7);
      end
      @(negedge clk);
    end
    check("ign_pulses", dcount, 1);
    $display("op ignore-test pulses=%0d", dcount);

    // start held high for 20 cycles: done every 5, busy low single cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.num = 6'd36;
    dcount = 0; lowcount = 0; last_done = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        if (last_done >= 0) check("thr_period", k - last_done, 5);
        last_done = k;
        dcount++;
      end
      if (!bus.busy) lowcount++;
    end
    bus.start = 1'b0;
    check("thr_pulses", dcount, 4);
    check("thr_idle", lowcount, 4);
    $display("op hold-start pulses=%0d idle_cycles=%0d", dcount, lowcount);
    repeat (3) @(negedge clk);

    // Reset in the 2nd CALC cycle of num=50 aborts without a done pulse.
    bus.start = 1'b1; bus.num = 6'd50;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_root", int'(bus.root), 0);
    check("abort_rem",  int'(bus.rem),  0);
    check("abort_perf", int'(bus.perfect), 0);
    dcount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    check("abort_nodone", dcount, 0);
    $display("op abort pulses_after=%0d", dcount);
    run_op(50, r, rm, pf);
    check("post_root", r, 7); check("post_rem", rm, 1); check("post_perf", pf, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
